multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle RV32I main decoder. Sequences each
//  instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a req/ready memory handshake.
//  Drives datapath strobes from state plus the latched opcode, and traps on illegal opcodes or
//  memory timeout. Sits between the IR/PC/regfile datapath and the shared instruction/data bus.
// PARAMETERS
//  ALUOP_W       2   aluop width; must be >=2; >=3 enables the I-type ALU mode encoding
//  MEM_WAIT_MAX  15  max cycles waiting on mem_ready before TRAP; 0 = no timeout
// PORTS
//  clk        in   1        rising-edge clock
//  reset      in   1        asynchronous, active-high
//  opcode     in   7        instr[6:0] from IR; sampled in DECODE only
//  mem_ready  in   1        bus accepted/returned this cycle; ignored outside FETCH/MEMORY
//  state      out  3        current state encoding, for debug
//  mem_req    out  1        bus request; held until mem_ready
//  memread    out  1        read access (FETCH, or MEMORY for LW)
//  memwrite   out  1        write access (MEMORY for SW)
//  ir_write   out  1        load IR = FETCH & mem_ready
//  pc_write   out  1        PC <= PC+4 = FETCH & mem_ready; also EXECUTE for jumps
//  branch     out  1        conditional PC update; datapath ANDs with ALU zero
//  jump       out  1        EXECUTE of JAL/JALR; selects jump target and link writeback
//  alusrc     out  1        1 = immediate operand B
//  memtoreg   out  1        1 = writeback from memory data
//  regwrite   out  1        register file write enable
//  aluop      out  ALUOP_W  ALU control class
//  trap       out  1        sticky fault flag
// BEHAVIOUR
//  - Regs: state, op_q[6:0], wait_cnt[$clog2(MEM_WAIT_MAX+1)-1:0]. All outputs decode
//    combinationally from (state, op_q, mem_ready). Unused/don't-care outputs are driven 0, never x.
//  - States: IDLE=0 FETCH=1 DECODE=2 EXECUTE=3 MEMORY=4 WRITEBACK=5 TRAP=7.
//  - Reset (async, any time, including mid-access): state=IDLE, op_q=0, wait_cnt=0, so every
//    output is 0. IDLE -> FETCH unconditionally on the next edge.
//  - FETCH: mem_req=memread=1. When mem_ready=1: ir_write=pc_write=1 and go to DECODE.
//  - DECODE: op_q<=opcode. Legal opcodes (0110011 R, 0010011 I, 0000011 LW, 0100011 SW,
//    1100011 BEQ) go to EXECUTE; anything else goes to TRAP.
//  - EXECUTE, by op_q:
//      R:       aluop=2'b10, alusrc=0; -> WRITEBACK
//      I:       alusrc=1, aluop=0 if ALUOP_W==2, else 3'b011; -> WRITEBACK
//      LW/SW:   alusrc=1, aluop=0; -> MEMORY
//      BEQ:     branch=1, aluop=2'b01, alusrc=0; -> FETCH
//    aluop upper bits are zero-extended when ALUOP_W>2.
//  - MEMORY: mem_req=1, memread=(LW), memwrite=(SW), held stable while waiting.
//    On mem_ready: LW -> WRITEBACK, SW -> FETCH.
//  - WRITEBACK: regwrite=1, memtoreg=(LW), then -> FETCH.
//  - Timeout: in FETCH/MEMORY with mem_ready=0, wait_cnt increments each cycle. If
//    MEM_WAIT_MAX!=0 and wait_cnt==MEM_WAIT_MAX with mem_ready still 0, go to TRAP.
//    wait_cnt clears on every state change. mem_ready on the terminal cycle wins (no trap).
//  - TRAP: trap=1, all other outputs 0. Exits only on reset.
//  - CPI: R/I=4, BEQ=3, SW=4, LW=5, each plus memory wait cycles.
// CONFIGURATION
//  CU_JUMP_EN defined:
//    JAL 1101111 and JALR 1100111 are legal. EXECUTE asserts jump=1 and pc_write=1;
//    alusrc=1 for JALR, 0 for JAL; aluop=0. Then WRITEBACK with regwrite=1, memtoreg=0.
//  CU_JUMP_EN undefined:
//    JAL/JALR are illegal and go to TRAP; jump is tied to 0.
// TESTING
//  1 Reset mid-MEMORY -> all outputs 0 while reset is high; state IDLE, then FETCH one cycle later.
//  2 R-type (0110011), mem_ready=1 in FETCH -> states 1,2,3,5,1; aluop=10 in EXECUTE;
//    regwrite=1 for exactly one cycle.
//  3 LW with mem_ready delayed 3 cycles in MEMORY -> memread and mem_req held 4 cycles;
//    WRITEBACK has memtoreg=1, regwrite=1.
//  4 BEQ -> branch=1 in EXECUTE only, aluop=01, next state FETCH, regwrite never asserted.
//  5 mem_ready stuck 0 in FETCH, MEM_WAIT_MAX=15 -> TRAP after 16 FETCH cycles; trap stays 1.
//    Same with mem_ready=1 on cycle 16 -> DECODE, no trap.
//  6 Opcode 1101111: CU_JUMP_EN on -> jump=pc_write=1 in EXECUTE, then regwrite;
//    CU_JUMP_EN off -> TRAP from DECODE.
//    Also ALUOP_W=3 with I-type -> aluop=3'b011.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Shared instruction/data bus handshake between the control unit and memory.
// The master raises mem_req and holds it until the slave answers with mem_ready.
interface multicycle_control_unit_if;
    logic mem_req;
    logic mem_ready;
    logic memread;
    logic memwrite;

    modport master (
        output mem_req,
        output memread,
        output memwrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  memread,
        input  memwrite,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, trap on fault.
// Define CU_JUMP_EN to make JAL/JALR legal; otherwise they trap and jump stays 0.
module multicycle_control_unit #(
    parameter int ALUOP_W      = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    multicycle_control_unit_if.master bus,
    output logic [2:0]          state,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                jump,
    output logic                alusrc,
    output logic                memtoreg,
    output logic                regwrite,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                trap
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd7
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // A zero-cycle limit still needs a one-bit counter to keep widths legal.
    localparam int WCW = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WCW-1:0] WMAX = WCW'(MEM_WAIT_MAX);

    state_t           state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [WCW-1:0]   cnt_q, cnt_d;

    logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, is_jalr;
    logic legal, waiting, timeout;

    assign is_r    = (op_q == OP_R);
    assign is_i    = (op_q == OP_I);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);
`ifdef CU_JUMP_EN
    assign is_jal  = (op_q == OP_JAL);
    assign is_jalr = (op_q == OP_JALR);
    assign legal   = (opcode == OP_R)   || (opcode == OP_I)
                  || (opcode == OP_LW)  || (opcode == OP_SW)
                  || (opcode == OP_BEQ) || (opcode == OP_JAL)
                  || (opcode == OP_JALR);
`else
    assign is_jal  = 1'b0;
    assign is_jalr = 1'b0;
    assign legal   = (opcode == OP_R)   || (opcode == OP_I)
                  || (opcode == OP_LW)  || (opcode == OP_SW)
                  || (opcode == OP_BEQ);
`endif

    assign waiting = ((state_q == FETCH) || (state_q == MEMORY))
                  && !bus.mem_ready;
    assign timeout = (MEM_WAIT_MAX != 0) && waiting && (cnt_q == WMAX);

    // State, latched opcode and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state sequencing, opcode capture and wait counting.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH: begin
                if (bus.mem_ready) state_d = DECODE;
                else if (timeout)  state_d = TRAP;
            end
            DECODE: begin
                op_d    = opcode;
                state_d = legal ? EXECUTE : TRAP;
            end
            EXECUTE: begin
                unique case (1'b1)
                    is_r, is_i:       state_d = WRITEBACK;
                    is_jal, is_jalr:  state_d = WRITEBACK;
                    is_lw, is_sw:     state_d = MEMORY;
                    is_beq:           state_d = FETCH;
                    default:          state_d = TRAP;
                endcase
            end
            MEMORY: begin
                if (bus.mem_ready) state_d = is_lw ? WRITEBACK : FETCH;
                else if (timeout)  state_d = TRAP;
            end
            WRITEBACK: state_d = FETCH;
            TRAP:      state_d = TRAP;
            default:   state_d = TRAP;
        endcase
        if (state_d != state_q) cnt_d = '0;
        else if (waiting)       cnt_d = cnt_q + WCW'(1);
        else                    cnt_d = cnt_q;
    end

    // Datapath strobes from state, latched opcode and mem_ready.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.memread  = 1'b0;
        bus.memwrite = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch       = 1'b0;
        jump         = 1'b0;
        alusrc       = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
        aluop        = '0;
        trap         = 1'b0;
        unique case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.memread = 1'b1;
                ir_write    = bus.mem_ready;
                pc_write    = bus.mem_ready;
            end
            EXECUTE: begin
                unique case (1'b1)
                    is_r:  aluop = ALUOP_W'(2'b10);
                    is_i: begin
                        alusrc = 1'b1;
                        aluop  = (ALUOP_W == 2) ? '0 : ALUOP_W'(3'b011);
                    end
                    is_lw, is_sw: alusrc = 1'b1;
                    is_beq: begin
                        branch = 1'b1;
                        aluop  = ALUOP_W'(2'b01);
                    end
                    is_jal, is_jalr: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        alusrc   = is_jalr;
                    end
                    default: ;
                endcase
            end
            MEMORY: begin
                bus.mem_req  = 1'b1;
                bus.memread  = is_lw;
                bus.memwrite = is_sw;
            end
            WRITEBACK: begin
                regwrite = 1'b1;
                memtoreg = is_lw;
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
